// File: rtl/ifetch_ctrl.sv
// Instruction-fetch controller: drives the sync-read ROM address, tracks
// the read in flight and buffers returned words in a 2-entry skid FIFO.
module ifetch_ctrl #(
    parameter logic [29:0] RESET_PC = 30'h0
) (
    input  logic        clk,
    input  logic        rst,
    output logic [29:0] imem_pc,
    input  logic [31:0] imem_inst,
    input  logic        redirect_valid,
    input  logic [29:0] redirect_pc,
    input  logic        halt_req,
    output logic        halted,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic [29:0] out_pc
);

    typedef enum logic {RUN, HALTED} state_t;

    state_t      state, state_nx;
    logic [29:0] fetch_pc;
    logic        infl_v;
    logic [29:0] infl_pc;
    logic [31:0] fifo_inst [2];
    logic [29:0] fifo_pc [2];
    logic        head;
    logic [1:0]  count;
    logic [1:0]  occ;
    logic        issue;
    logic        pop;
    logic        byp_take;
    logic        push;
    logic        wr_idx;

    assign imem_pc  = redirect_valid ? redirect_pc : fetch_pc;
    assign occ      = count + {1'b0, infl_v};
    assign issue    = redirect_valid ||
                      (state == RUN && !halt_req && occ <= 2'd1);
    assign pop      = (count != 2'd0) && out_ready;
    assign byp_take = (count == 2'd0) && infl_v && out_ready;
    assign push     = infl_v && !byp_take;
    assign wr_idx   = head ^ count[0];
    assign halted   = (state == HALTED);

    // FIFO head has priority; the bypass path is also shown when idle
    always_comb begin
        out_valid = 1'b0;
        out_inst  = imem_inst;
        out_pc    = infl_pc;
        if (count != 2'd0) begin
            out_valid = 1'b1;
            out_inst  = fifo_inst[head];
            out_pc    = fifo_pc[head];
        end else if (infl_v) begin
            out_valid = 1'b1;
        end
    end

    always_comb begin
        state_nx = state;
        if (redirect_valid) begin
            state_nx = RUN;
        end else if (halt_req) begin
            state_nx = HALTED;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc     <= RESET_PC;
            infl_v       <= 1'b0;
            infl_pc      <= RESET_PC;
            head         <= 1'b0;
            count        <= 2'd0;
            fifo_inst[0] <= 32'h0;
            fifo_inst[1] <= 32'h0;
            fifo_pc[0]   <= RESET_PC;
            fifo_pc[1]   <= RESET_PC;
        end else begin
            if (issue) begin
                infl_v   <= 1'b1;
                infl_pc  <= imem_pc;
                fetch_pc <= imem_pc + 30'd1;
            end else begin
                infl_v   <= 1'b0;
            end
            // Redirect drops both buffered words and the returning read
            if (redirect_valid) begin
                head  <= 1'b0;
                count <= 2'd0;
            end else begin
                if (push) begin
                    fifo_inst[wr_idx] <= imem_inst;
                    fifo_pc[wr_idx]   <= infl_pc;
                end
                if (pop) begin
                    head <= ~head;
                end
                count <= count - {1'b0, pop} + {1'b0, push};
            end
        end
    end

    assert property (@(posedge clk) disable iff (rst)
        !(push && !pop && !redirect_valid && count == 2'd2));

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Bench for ifetch_ctrl: directed table, corner sequences and a random run
// against a queue-of-outstanding-PCs reference model.
module tb_ifetch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [29:0] imem_pc;
    logic [31:0] imem_inst;
    logic        redirect_valid;
    logic [29:0] redirect_pc;
    logic        halt_req;
    logic        halted;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [29:0] out_pc;

    int checks = 0;
    int failures = 0;

    ifetch_ctrl #(.RESET_PC(30'h0)) dut (
        .clk(clk), .rst(rst),
        .imem_pc(imem_pc), .imem_inst(imem_inst),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .halt_req(halt_req), .halted(halted),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_inst(out_inst), .out_pc(out_pc)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rom(input logic [29:0] a);
        return {a, 2'b01} ^ 32'h9E37_79B9;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) imem_inst <= 32'h0;
        else     imem_inst <= rom(imem_pc);
    end

    // Model: PCs issued but not yet handed to decode, oldest first
    logic [29:0] q[$];
    logic [29:0] npc;
    bit          mhalt;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp,
                     $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        npc   = 30'h0;
        mhalt = 1'b0;
    endtask

    task automatic drive(input logic rv, input logic [29:0] rpc,
                         input logic h, input logic rd);
        redirect_valid = rv;
        redirect_pc    = rpc;
        halt_req       = h;
        out_ready      = rd;
        @(negedge clk);
        chk("valid", out_valid, q.size() > 0);
        if (q.size() > 0) begin
            chk("pc", out_pc, q[0]);
            chk("inst", out_inst, rom(q[0]));
        end
        chk("imem_pc", imem_pc, rv ? rpc : npc);
        chk("halted", halted, mhalt);
    endtask

    task automatic adv();
        bit xfer;
        int occ;
        xfer = (q.size() > 0) && out_ready;
        occ  = q.size();
        @(posedge clk);
        if (redirect_valid) begin
            q.delete();
            q.push_back(redirect_pc);
            npc   = redirect_pc + 30'd1;
            mhalt = 1'b0;
        end else begin
            if (xfer) void'(q.pop_front());
            if (!mhalt && !halt_req && occ <= 1) begin
                q.push_back(npc);
                npc = npc + 30'd1;
            end
            if (halt_req) mhalt = 1'b1;
        end
        #1;
    endtask

    task automatic cyc(input logic rv, input logic [29:0] rpc,
                       input logic h, input logic rd);
        drive(rv, rpc, h, rd);
        adv();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = 30'h0;
        halt_req = 1'b0;
        out_ready = 1'b1;
        #1;
        model_reset();
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_pc", out_pc, 30'h0);
        chk("rst_inst", out_inst, 32'h0);
        chk("rst_halted", halted, 1'b0);
        chk("rst_imem", imem_pc, 30'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    typedef struct {
        logic        rv;
        logic [29:0] rpc;
        logic        h;
        logic        rd;
        logic        ev;
        logic [29:0] epc;
        logic        eh;
        logic [29:0] eimem;
    } vec_t;

    vec_t tv[11];

    initial begin
        tv[0]  = '{1'b0, 30'h0,  1'b0, 1'b1, 1'b0, 30'h0,  1'b0, 30'h0};
        tv[1]  = '{1'b0, 30'h0,  1'b0, 1'b1, 1'b1, 30'h0,  1'b0, 30'h1};
        tv[2]  = '{1'b0, 30'h0,  1'b0, 1'b0, 1'b1, 30'h1,  1'b0, 30'h2};
        tv[3]  = '{1'b0, 30'h0,  1'b0, 1'b0, 1'b1, 30'h1,  1'b0, 30'h3};
        tv[4]  = '{1'b0, 30'h0,  1'b0, 1'b0, 1'b1, 30'h1,  1'b0, 30'h3};
        tv[5]  = '{1'b0, 30'h0,  1'b0, 1'b1, 1'b1, 30'h1,  1'b0, 30'h3};
        tv[6]  = '{1'b0, 30'h0,  1'b0, 1'b1, 1'b1, 30'h2,  1'b0, 30'h3};
        tv[7]  = '{1'b0, 30'h0,  1'b1, 1'b1, 1'b1, 30'h3,  1'b0, 30'h4};
        tv[8]  = '{1'b1, 30'h10, 1'b0, 1'b1, 1'b0, 30'h0,  1'b1, 30'h10};
        tv[9]  = '{1'b0, 30'h0,  1'b0, 1'b1, 1'b1, 30'h10, 1'b0, 30'h11};
        tv[10] = '{1'b0, 30'h0,  1'b0, 1'b1, 1'b1, 30'h11, 1'b0, 30'h12};

        do_reset();

        for (int i = 0; i < 11; i++) begin
            drive(tv[i].rv, tv[i].rpc, tv[i].h, tv[i].rd);
            chk($sformatf("tab%0d_valid", i), out_valid, tv[i].ev);
            if (tv[i].ev)
                chk($sformatf("tab%0d_pc", i), out_pc, tv[i].epc);
            chk($sformatf("tab%0d_halt", i), halted, tv[i].eh);
            chk($sformatf("tab%0d_imem", i), imem_pc, tv[i].eimem);
            adv();
        end

        // Redirect while the skid FIFO holds two words
        for (int i = 0; i < 3; i++) cyc(1'b0, 30'h0, 1'b0, 1'b0);
        cyc(1'b1, 30'h40, 1'b0, 1'b0);
        chk("redir_valid", out_valid, 1'b1);
        chk("redir_pc0", out_pc, 30'h40);
        cyc(1'b0, 30'h0, 1'b0, 1'b1);
        chk("redir_pc1", out_pc, 30'h41);

        // Redirect and halt together: halt is ignored
        cyc(1'b1, 30'h20, 1'b1, 1'b1);
        chk("rh_halted", halted, 1'b0);
        chk("rh_pc", out_pc, 30'h20);
        cyc(1'b0, 30'h0, 1'b0, 1'b1);
        chk("rh_pc1", out_pc, 30'h21);

        // Address wrap
        cyc(1'b1, 30'h3FFFFFFE, 1'b0, 1'b1);
        cyc(1'b0, 30'h0, 1'b0, 1'b1);
        chk("wrap_a", out_pc, 30'h3FFFFFFF);
        cyc(1'b0, 30'h0, 1'b0, 1'b1);
        chk("wrap_b", out_pc, 30'h0);
        cyc(1'b0, 30'h0, 1'b0, 1'b1);

        // Asynchronous reset with FIFO full
        for (int i = 0; i < 3; i++) cyc(1'b0, 30'h0, 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_valid", out_valid, 1'b0);
        chk("async_rst_halted", halted, 1'b0);
        do_reset();
        cyc(1'b0, 30'h0, 1'b0, 1'b1);
        chk("restart_pc", out_pc, 30'h0);
        chk("restart_valid", out_valid, 1'b1);

        for (int i = 0; i < 3000; i++) begin
            logic        rv;
            logic [29:0] rpc;
            rv  = ($urandom_range(0, 15) == 0);
            rpc = ($urandom_range(0, 3) == 0)
                  ? 30'h3FFFFFFC + 30'($urandom_range(0, 3))
                  : 30'($urandom);
            cyc(rv, rpc, $urandom_range(0, 11) == 0,
                $urandom_range(0, 3) != 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
